// File: rtl/cp0_exc_ctrl_if.sv
// Bus bundle between the pipeline commit point / CP0 register file and the exception
// sequencer (cp0_exc_ctrl).
//
// Pipeline/CP0 to controller:
//   commit_*, exc_*, eret   commit-point instruction and its exception status
//   mtc0_*                  MTC0 write request
//   hw_int                  asynchronous hardware interrupt lines
//   status, epc_in          current CP0 Status and EPC
// Controller to pipeline/CP0:
//   cp0_*                   CP0 write strobes and write data
//   hw_int_sync             synchronised interrupt lines for Cause.IP
//   mtc0_ack                MTC0 accepted
//   flush, redirect_*       pipeline kill and PC redirect
//   busy                    controller is sequencing a trigger
//
// modport master: the pipeline/CP0 side. modport slave: the controller.

interface cp0_exc_ctrl_if;

  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_has_badv;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        mtc0_req;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [5:0]  hw_int;
  logic [31:0] status;
  logic [31:0] epc_in;

  logic [31:0] cp0_we;
  logic        cp0_gen_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_badaddr;
  logic [4:0]  cp0_exc_code;
  logic        cp0_bd;
  logic        cp0_exl;
  logic        cp0_ie;
  logic [7:0]  cp0_int_en;
  logic [5:0]  hw_int_sync;
  logic        mtc0_ack;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output commit_valid, commit_pc, commit_bd, exc_valid, exc_code, exc_has_badv,
           exc_badvaddr, eret, mtc0_req, mtc0_addr, mtc0_data, hw_int, status, epc_in,
    input  cp0_we, cp0_gen_we, cp0_waddr, cp0_wdata, cp0_epc, cp0_badaddr, cp0_exc_code,
           cp0_bd, cp0_exl, cp0_ie, cp0_int_en, hw_int_sync, mtc0_ack, flush,
           redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  commit_valid, commit_pc, commit_bd, exc_valid, exc_code, exc_has_badv,
           exc_badvaddr, eret, mtc0_req, mtc0_addr, mtc0_data, hw_int, status, epc_in,
    output cp0_we, cp0_gen_we, cp0_waddr, cp0_wdata, cp0_epc, cp0_badaddr, cp0_exc_code,
           cp0_bd, cp0_exl, cp0_ie, cp0_int_en, hw_int_sync, mtc0_ack, flush,
           redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception / interrupt sequencer.
//
// Samples the commit point, synchronises the hardware interrupt lines and arbitrates
// between exception, interrupt, ERET and MTC0 requests (that priority order, only while
// idle). It is the single writer of CP0: on exception/interrupt entry it writes EPC,
// Cause, Status (and BadVAddr when present); on ERET it clears Status.EXL. Every trigger
// flushes the pipeline for FLUSH_CYCLES cycles and pulses a PC redirect.
//
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  cp0_exc_ctrl_if.slave, all request inputs and CP0/pipeline control outputs
//
// Parameters:
//   EXC_VECTOR    PC loaded on exception or interrupt entry
//   FLUSH_CYCLES  cycles flush is held per trigger, 1..15

module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  cp0_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEntry, StRet, StFlush} state_e;

  // CP0 register numbers written on entry/return.
  localparam int unsigned RegBadVAddr = 8;
  localparam int unsigned RegStatus   = 12;
  localparam int unsigned RegCause    = 13;
  localparam int unsigned RegEpc      = 14;

  // Count of FLUSH-state cycles still to go after the current one; the FLUSH state
  // covers FLUSH_CYCLES-1 cycles because ENTRY/RET already flush for one.
  localparam logic [3:0] FlushLoad = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;

  logic [5:0]  sync1_q, sync2_q;

  logic [31:0] we_q, we_d;
  logic        gen_we_q, gen_we_d;
  logic        ack_q, ack_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badaddr_q, badaddr_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        bd_q, bd_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [7:0]  int_en_q, int_en_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        int_pend;
  logic        trig_exc, trig_int, trig_eret;
  logic [31:0] unused_status_bits;

  // Status bits this block does not interpret.
  assign unused_status_bits = {bus.status[31:16], 8'h00, bus.status[7:2], 2'b00};

  // IE set, EXL clear, and at least one unmasked synchronised line.
  assign int_pend  = bus.status[0] & ~bus.status[1] & (|(sync2_q & bus.status[15:10]));

  assign trig_exc  = bus.commit_valid & bus.exc_valid;
  assign trig_int  = bus.commit_valid & int_pend;
  assign trig_eret = bus.commit_valid & bus.eret;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    we_d             = '0;
    gen_we_d         = 1'b0;
    ack_d            = 1'b0;
    redirect_valid_d = 1'b0;
    waddr_d          = waddr_q;
    wdata_d          = wdata_q;
    epc_d            = epc_q;
    badaddr_d        = badaddr_q;
    exc_code_d       = exc_code_q;
    bd_d             = bd_q;
    exl_d            = exl_q;
    ie_d             = ie_q;
    int_en_d         = int_en_q;
    redirect_pc_d    = redirect_pc_q;

    unique case (state_q)
      StIdle: begin
        if (trig_exc || trig_int) begin
          state_d               = StEntry;
          epc_d                 = bus.commit_bd ? (bus.commit_pc - 32'd4) : bus.commit_pc;
          bd_d                  = bus.commit_bd;
          exc_code_d            = trig_exc ? bus.exc_code : 5'd0;
          badaddr_d             = bus.exc_badvaddr;
          exl_d                 = 1'b1;
          ie_d                  = bus.status[0];
          int_en_d              = bus.status[15:8];
          we_d[RegStatus]       = 1'b1;
          we_d[RegCause]        = 1'b1;
          we_d[RegEpc]          = 1'b1;
          // An interrupt never carries a bad address, whatever exc_has_badv shows.
          we_d[RegBadVAddr]     = trig_exc & bus.exc_has_badv;
          redirect_valid_d      = 1'b1;
          redirect_pc_d         = EXC_VECTOR;
        end else if (trig_eret) begin
          state_d               = StRet;
          exl_d                 = 1'b0;
          ie_d                  = bus.status[0];
          int_en_d              = bus.status[15:8];
          we_d[RegStatus]       = 1'b1;
          redirect_valid_d      = 1'b1;
          redirect_pc_d         = bus.epc_in;
        end else if (bus.mtc0_req) begin
          ack_d                 = 1'b1;
          gen_we_d              = 1'b1;
          waddr_d               = bus.mtc0_addr;
          wdata_d               = bus.mtc0_data;
        end
      end
      StEntry, StRet: begin
        if (FLUSH_CYCLES <= 1) begin
          state_d = StIdle;
        end else begin
          state_d     = StFlush;
          flush_cnt_d = FlushLoad;
        end
      end
      StFlush: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      flush_cnt_q      <= '0;
      sync1_q          <= '0;
      sync2_q          <= '0;
      we_q             <= '0;
      gen_we_q         <= 1'b0;
      ack_q            <= 1'b0;
      waddr_q          <= '0;
      wdata_q          <= '0;
      epc_q            <= '0;
      badaddr_q        <= '0;
      exc_code_q       <= '0;
      bd_q             <= 1'b0;
      exl_q            <= 1'b0;
      ie_q             <= 1'b0;
      int_en_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      sync1_q          <= bus.hw_int;
      sync2_q          <= sync1_q;
      we_q             <= we_d;
      gen_we_q         <= gen_we_d;
      ack_q            <= ack_d;
      waddr_q          <= waddr_d;
      wdata_q          <= wdata_d;
      epc_q            <= epc_d;
      badaddr_q        <= badaddr_d;
      exc_code_q       <= exc_code_d;
      bd_q             <= bd_d;
      exl_q            <= exl_d;
      ie_q             <= ie_d;
      int_en_q         <= int_en_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // flush and busy decode the state register directly so they fall with rst.
  assign bus.flush          = (state_q != StIdle);
  assign bus.busy           = (state_q != StIdle);
  assign bus.cp0_we         = we_q;
  assign bus.cp0_gen_we     = gen_we_q;
  assign bus.cp0_waddr      = waddr_q;
  assign bus.cp0_wdata      = wdata_q;
  assign bus.cp0_epc        = epc_q;
  assign bus.cp0_badaddr    = badaddr_q;
  assign bus.cp0_exc_code   = exc_code_q;
  assign bus.cp0_bd         = bd_q;
  assign bus.cp0_exl        = exl_q;
  assign bus.cp0_ie         = ie_q;
  assign bus.cp0_int_en     = int_en_q;
  assign bus.hw_int_sync    = sync2_q;
  assign bus.mtc0_ack       = ack_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule
